// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and constants for the HUB75 scan driver.
// Holds the FSM state enum, pixel field offsets inside a frame-buffer word,
// and the gamma-2.2 constant function used to build the optional LUT.
package hub75_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } state_t;

  // Pixel placement inside a 48-bit frame-buffer word.
  localparam int unsigned UPPER_OFS = 0;
  localparam int unsigned LOWER_OFS = 24;

  // Channel placement inside a 24-bit pixel.
  localparam int unsigned R_OFS = 16;
  localparam int unsigned G_OFS = 8;
  localparam int unsigned B_OFS = 0;

  localparam real GAMMA = 2.2;

  // Elaboration-time gamma curve: floor(255 * (x/255)^2.2).
  function automatic logic [7:0] gamma22(input int unsigned x);
    real v;
    v = 255.0 * ((real'(x) / 255.0) ** GAMMA);
    return 8'($rtoi(v));
  endfunction

endpackage

// File: rtl/hub75_scan_driver_if.sv
// hub75_scan_driver_if: synchronous frame-buffer read port.
// master = scan driver (issues rd_addr), slave = frame-buffer RAM.
interface hub75_scan_driver_if;
  logic [9:0]  rd_addr;
  logic [47:0] rd_data;

  modport master (output rd_addr, input rd_data);
  modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/hub75_gamma_lut.sv
// hub75_gamma_lut: 256-entry gamma-2.2 table, combinational lookup.
// Only instantiated when HUB75_GAMMA_EN is defined.
module hub75_gamma_lut (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  import hub75_pkg::*;

  logic [7:0] lut [256];

  for (genvar i = 0; i < 256; i++) begin : g_lut
    localparam logic [7:0] V = gamma22(i);
    assign lut[i] = V;
  end

  // Table lookup.
  always_comb dout = lut[din];

endmodule

// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver: reads a 1024x48 frame buffer and scans a 64x32 1/16
// HUB75 panel with 8-plane binary-coded modulation.
// Optional feature: define HUB75_GAMMA_EN to route every channel through a
// gamma-2.2 LUT before plane-bit selection.
module hub75_scan_driver
  import hub75_pkg::*;
#(
  parameter int unsigned COLS    = 64,
  parameter int unsigned ROWS    = 16,
  parameter int unsigned BITS    = 8,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned BASE_ON = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  hub75_scan_driver_if.master fb,
  output logic                r1,
  output logic                g1,
  output logic                b1,
  output logic                r2,
  output logic                g2,
  output logic                b2,
  output logic [3:0]          row_sel,
  output logic                panel_clk,
  output logic                lat,
  output logic                oe_n,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned CW  = $clog2(COLS);
  localparam int unsigned RW  = $clog2(ROWS);
  localparam int unsigned PW  = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int unsigned PHW = $clog2(2 * CLK_DIV);
  localparam int unsigned DW  = $clog2(BASE_ON << (BITS - 1)) + 1;

  localparam logic [CW-1:0]  COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);
  localparam logic [PW-1:0]  PL_LAST  = PW'(BITS - 1);
  localparam logic [PHW-1:0] PH_LAST  = PHW'(2 * CLK_DIV - 1);
  localparam logic [PHW-1:0] PH_HI    = PHW'(CLK_DIV);
  localparam logic [PHW-1:0] PH_CAP   = PHW'(1);

  state_t         state, nxt_state;
  logic [RW-1:0]  row, nxt_row;
  logic [CW-1:0]  col, nxt_col;
  logic [PW-1:0]  plane, nxt_plane;
  logic [PHW-1:0] ph, nxt_ph;
  logic [DW-1:0]  dcnt, nxt_dcnt;
  logic [DW-1:0]  on_last;

  logic [5:0][7:0] raw;
  logic [5:0][7:0] ch;

  // Last DISPLAY count for the current plane (BASE_ON << plane cycles).
  always_comb on_last = (DW'(BASE_ON) << plane) - DW'(1);

  // State and scan counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      row   <= '0;
      col   <= '0;
      plane <= '0;
      ph    <= '0;
      dcnt  <= '0;
    end else begin
      state <= nxt_state;
      row   <= nxt_row;
      col   <= nxt_col;
      plane <= nxt_plane;
      ph    <= nxt_ph;
      dcnt  <= nxt_dcnt;
    end
  end

  // Next-state, counter advance and end-of-frame pulse.
  always_comb begin
    nxt_state  = state;
    nxt_row    = row;
    nxt_col    = col;
    nxt_plane  = plane;
    nxt_ph     = ph;
    nxt_dcnt   = dcnt;
    frame_done = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable) begin
          nxt_state = ST_SHIFT;
          nxt_row   = '0;
          nxt_col   = '0;
          nxt_plane = '0;
          nxt_ph    = '0;
        end
      end
      ST_SHIFT: begin
        if (ph == PH_LAST) begin
          nxt_ph = '0;
          if (col == COL_LAST) begin
            nxt_col   = '0;
            nxt_state = ST_LATCH;
          end else begin
            nxt_col = col + CW'(1);
          end
        end else begin
          nxt_ph = ph + PHW'(1);
        end
      end
      ST_LATCH: begin
        nxt_state = ST_DISPLAY;
        nxt_dcnt  = '0;
      end
      ST_DISPLAY: begin
        if (dcnt == on_last) begin
          nxt_state = ST_SHIFT;
          if (plane == PL_LAST) begin
            nxt_plane = '0;
            if (row == ROW_LAST) begin
              nxt_row    = '0;
              frame_done = 1'b1;
              if (!enable) nxt_state = ST_IDLE;
            end else begin
              nxt_row = row + RW'(1);
            end
          end else begin
            nxt_plane = plane + PW'(1);
          end
        end else begin
          nxt_dcnt = dcnt + DW'(1);
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // Panel control strobes decoded from state.
  always_comb begin
    busy       = (state != ST_IDLE);
    panel_clk  = (state == ST_SHIFT) && (ph >= PH_HI);
    lat        = (state == ST_LATCH);
    oe_n       = (state != ST_DISPLAY);
    fb.rd_addr = 10'({row, col});
  end

  // Split the read word into its six colour channels.
  always_comb begin
    raw[0] = fb.rd_data[UPPER_OFS + R_OFS +: 8];
    raw[1] = fb.rd_data[UPPER_OFS + G_OFS +: 8];
    raw[2] = fb.rd_data[UPPER_OFS + B_OFS +: 8];
    raw[3] = fb.rd_data[LOWER_OFS + R_OFS +: 8];
    raw[4] = fb.rd_data[LOWER_OFS + G_OFS +: 8];
    raw[5] = fb.rd_data[LOWER_OFS + B_OFS +: 8];
  end

`ifdef HUB75_GAMMA_EN
  for (genvar i = 0; i < 6; i++) begin : g_gamma
    hub75_gamma_lut u_lut (
      .din  (raw[i]),
      .dout (ch[i])
    );
  end
`else
  // Channels used as stored.
  always_comb ch = raw;
`endif

  // Colour bits captured in shift phase 1; row_sel follows on plane-0 latch.
  // Both are cleared whenever the block is (or is about to be) idle.
  always_ff @(posedge clk) begin
    if (rst || nxt_state == ST_IDLE) begin
      {r1, g1, b1, r2, g2, b2} <= '0;
      row_sel                  <= '0;
    end else begin
      if (state == ST_SHIFT && ph == PH_CAP)
        {r1, g1, b1, r2, g2, b2} <= {ch[0][plane], ch[1][plane], ch[2][plane],
                                     ch[3][plane], ch[4][plane], ch[5][plane]};
      if (nxt_state == ST_LATCH && plane == '0)
        row_sel <= 4'(row);
    end
  end

endmodule

// File: doc/hub75_scan_driver.md
# hub75_scan_driver

Consumer of the 1024×48-bit frame buffer that the SDRAM DMA fills. Reads the buffer through a synchronous read port and drives a 64×32, 1/16-scan HUB75 LED panel with 8-bit binary-coded modulation (BCM) per colour channel. Each buffer word holds two pixels: one for the upper half of the panel and one for the lower half. Sits between the frame-buffer RAM read port and the panel connector pins.

## Interface
Parameters:
- COLS, 64, pixels shifted per row; address bits [5:0].
- ROWS, 16, scanned row pairs; address bits [9:6].
- BITS, 8, BCM planes per channel.
- CLK_DIV, 2, clk cycles per panel_clk phase; minimum 2.
- BASE_ON, 8, oe_n-low cycles for plane 0.

Ports (reset rst, synchronous, active-high; clock clk):
- clk, in, 1, system clock; also the frame-buffer read clock.
- rst, in, 1, synchronous active-high reset.
- enable, in, 1, run frames; sampled in IDLE and at each frame end.
- rd_addr, out, 10, frame-buffer read address {row[3:0], col[5:0]}.
- rd_data, in, 48, read data, valid 1 cycle after rd_addr; [23:0] upper pixel, [47:24] lower pixel; each is {R[23:16], G[15:8], B[7:0]}.
- r1 g1 b1 r2 g2 b2, out, 1 each, panel colour bits.
- row_sel, out, 4, panel row address A..D.
- panel_clk, out, 1, panel shift clock.
- lat, out, 1, latch strobe.
- oe_n, out, 1, output enable, active low.
- busy, out, 1, high in any state except IDLE.
- frame_done, out, 1, one-cycle pulse at the end of a frame.

## Operation
- States: IDLE, SHIFT, LATCH, DISPLAY.
- IDLE: outputs hold their reset values. If enable=1, go to SHIFT with row=0, plane=0, col=0.
- SHIFT: each column occupies 2·CLK_DIV cycles.
  - Phase cycle 0: drive rd_addr = {row, col}.
  - Cycle 1: register colour outputs from bit `plane` of each channel in rd_data.
  - panel_clk is low for cycles 0..CLK_DIV-1 and high for CLK_DIV..2·CLK_DIV-1.
  - After the last cycle of col=COLS-1, go to LATCH.
- LATCH: 1 cycle with lat=1, panel_clk=0, oe_n=1. If plane=0, row_sel updates to the current row in this cycle. Next state is DISPLAY.
- DISPLAY: oe_n=0 for exactly BASE_ON<<plane cycles, then:
  - plane < BITS-1: plane+1, go to SHIFT.
  - Otherwise plane=0 and row+1, go to SHIFT.
  - After row=ROWS-1 and plane=BITS-1: pulse frame_done, then go to SHIFT (row=0) if enable=1, else IDLE.
- oe_n is high in every state except DISPLAY, so shifting never overlaps display and row_sel never changes while the panel is lit.
- The DISPLAY counter width is clog2(BASE_ON<<(BITS-1))+1.
- row and col wrap modulo ROWS and COLS.

## Timing
- Reset values: rd_addr=0, all colour outputs=0, row_sel=0, panel_clk=0, lat=0, oe_n=1, busy=0, frame_done=0. The state becomes IDLE.
- Cycles per plane: COLS·2·CLK_DIV + 1 + (BASE_ON<<plane). There are no other inter-state cycles.
- With defaults: 4096 cycles per row and 65536 per frame.
- IDLE→SHIFT costs 1 cycle. frame_done asserts in the last DISPLAY cycle of the frame.
- enable deasserted mid-frame: the current frame completes, then the block goes to IDLE.
- rst mid-frame: reset values are present in the next cycle, so oe_n=1 immediately.
- rd_data is ignored outside SHIFT phase cycle 1.

## Configuration
- HUB75_GAMMA_EN defined: each 8-bit channel passes through a 256-entry gamma-2.2 LUT before plane-bit selection. The LUT is combinational on rd_data, so there is no latency change.
- HUB75_GAMMA_EN undefined: channel bits are taken directly from rd_data.

## Structure
- Package hub75_pkg holds:
  - the state enum;
  - pixel field offsets (R/G/B and upper/lower);
  - the gamma LUT constant function/array.
- Sub-module hub75_gamma_lut (8-bit in, 8-bit out) is instantiated six times, only under HUB75_GAMMA_EN.

## Test plan
- Reset and idle: hold rst, then release with enable=0 → oe_n=1, busy=0, and all other outputs 0 for 100 cycles.
- All-white frame (every word 0xFFFFFF_FFFFFF), enable=1 → r1..b2=1 at every panel_clk rise; frame_done at cycle 65537 after enable.
- BCM weights: capture oe_n low pulse widths for row 0 → 8, 16, 32, 64, 128, 256, 512, 1024 cycles, each preceded by exactly 64 panel_clk rises and one lat pulse.
- Bit selection: word[row 3, col 5]=0x000000_800000, all other words 0 → r1=1 only at col 5 of row 3, plane 7; g/b and lower bits always 0.
- Row sequencing and early stop: drop enable at row 7 → row_sel steps 0..15 changing only while oe_n=1; one frame_done; then IDLE.
- With HUB75_GAMMA_EN: pixel 0x808080 → plane bits match LUT[0x80]=0x37, so planes 0, 1, 2, 4, 5 are set.
